// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Loadable, parameterized down-counting timer. A value loaded through
// load_en/data_in is counted down to zero once started; reaching zero after a
// decrement raises a one-cycle terminal-count pulse. With auto_reload set,
// the expiry cycle reloads the last loaded value and the timer keeps running,
// giving a periodic tick every R+1 cycles.
//
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   load_en     in   load data_in into count and reload register (top priority)
//   data_in     in   [N-1:0] load value
//   start       in   begin/resume counting (ignored when count is zero)
//   stop        in   pause counting, count held
//   auto_reload in   on expiry, reload instead of halting
//   count_out   out  [N-1:0] current count (registered)
//   tc          out  terminal-count pulse, one cycle (registered)
//   busy        out  high while running (registered)
// -----------------------------------------------------------------------------
module countdown_timer #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_en,
  input  logic [N-1:0] data_in,
  input  logic         start,
  input  logic         stop,
  input  logic         auto_reload,
  output logic [N-1:0] count_out,
  output logic         tc,
  output logic         busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [N-1:0] ZERO_C = {N{1'b0}};
  localparam logic [N-1:0] ONE_C  = {{(N-1){1'b0}}, 1'b1};

  logic [0:0]   state_r;
  logic [0:0]   state_s;
  logic [N-1:0] count_r;
  logic [N-1:0] count_s;
  logic [N-1:0] reload_r;
  logic [N-1:0] reload_s;
  logic         tc_r;
  logic         tc_s;

  // Next-state logic: load beats stop beats start; tc only on the 1 -> 0 step.
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    reload_s = reload_r;
    tc_s     = 1'b0;
    if (load_en) begin
      count_s  = data_in;
      reload_s = data_in;
      state_s  = IDLE;
    end else if (stop) begin
      // Pausing holds the count; a stop in IDLE changes nothing.
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          // Starting from zero would only produce an immediate expiry, so it is ignored.
          if (start && (count_r != ZERO_C)) begin
            state_s = RUN;
          end else begin
            state_s = IDLE;
          end
        end
        RUN: begin
          if (count_r == ZERO_C) begin
            // Expiry cycle: the only point where auto_reload is looked at.
            if (auto_reload && (reload_r != ZERO_C)) begin
              count_s = reload_r;
              state_s = RUN;
            end else begin
              state_s = IDLE;
            end
          end else if (count_r == ONE_C) begin
            count_s = ZERO_C;
            tc_s    = 1'b1;
          end else begin
            count_s = count_r - ONE_C;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State, count, reload and terminal-count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      count_r  <= ZERO_C;
      reload_r <= ZERO_C;
      tc_r     <= 1'b0;
    end else begin
      state_r  <= state_s;
      count_r  <= count_s;
      reload_r <= reload_s;
      tc_r     <= tc_s;
    end
  end

  assign count_out = count_r;
  assign tc        = tc_r;
  assign busy      = (state_r == RUN);

endmodule
